// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared field ranges, sizes and loader state codes for the sprite pipeline
package sprite_pkg;

  // Pixel stream layout
  localparam int STR_W      = 26;
  localparam int RGB_MSB    = 25;
  localparam int RGB_LSB    = 23;
  localparam int XC_MSB     = 22;
  localparam int XC_LSB     = 13;
  localparam int YC_MSB     = 12;
  localparam int YC_LSB     = 3;
  localparam int ACTIVE_BIT = 2;
  localparam int VSYNC_BIT  = 1;
  localparam int HSYNC_BIT  = 0;

  // Sprite geometry
  localparam int SPRITE_W  = 16;
  localparam int SPRITE_H  = 16;
  localparam int N_BITMAPS = 8;

  // Bitmap address layout: {bitmap, row, bit}
  localparam int ADDR_W     = 11;
  localparam int AD_BMP_MSB = 10;
  localparam int AD_BMP_LSB = 8;
  localparam int AD_ROW_MSB = 7;
  localparam int AD_ROW_LSB = 4;
  localparam int AD_BIT_MSB = 3;
  localparam int AD_BIT_LSB = 0;

  // Row memory geometry: one word per bitmap row
  localparam int RAM_AW = 7;
  localparam int RAM_DW = 16;

  // Loader state encoding
  localparam logic [1:0] LD_IDLE = 2'd0;
  localparam logic [1:0] LD_LOAD = 2'd1;
  localparam logic [1:0] LD_DONE = 2'd2;

  // Unsigned span test; no wrap past the top of the 10-bit coordinate range
  function automatic logic in_span(input logic [9:0] c, input logic [9:0] origin,
                                   input logic [9:0] span);
    logic [9:0] diff;
    diff = c - origin;
    return (c >= origin) && (diff < span);
  endfunction

endpackage

// File: rtl/sprite_overlay_if.sv
// rtl/sprite_overlay_if.sv - bitmap row loader handshake bundle
interface sprite_overlay_if;
  logic        ld_start_i;
  logic [2:0]  ld_bitmap_i;
  logic        ld_valid_i;
  logic [15:0] ld_data_i;
  logic        ld_ready_o;
  logic        ld_done_o;

  // Row source side
  modport master (
    output ld_start_i, ld_bitmap_i, ld_valid_i, ld_data_i,
    input  ld_ready_o, ld_done_o
  );

  // Loader side inside the sprite stage
  modport slave (
    input  ld_start_i, ld_bitmap_i, ld_valid_i, ld_data_i,
    output ld_ready_o, ld_done_o
  );
endinterface

// File: rtl/sprite_row_ram.sv
// rtl/sprite_row_ram.sv - 128x16 bitmap row memory, one write port and one registered read port
module sprite_row_ram
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [RAM_DW-1:0] wdata,
  input  logic [RAM_AW-1:0] raddr,
  output logic [RAM_DW-1:0] rdata
);

  logic [RAM_DW-1:0] mem [2**RAM_AW];

  // Write port; contents survive reset so a partial load is preserved
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; a same-address write in this cycle is not yet visible (old data)
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_overlay.sv
// rtl/sprite_overlay.sv - sprite colour overlay stage with bitmap row loader
module sprite_overlay
  import sprite_pkg::*;
(
  input  logic               px_clk,
  input  logic               reset_n,
  input  logic [STR_W-1:0]   RGBStr_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [9:0]         posx_i,
  input  logic [9:0]         posy_i,
  input  logic [2:0]         color_i,
  input  logic               enable_i,
  output logic [STR_W-1:0]   RGBStr_o,
  sprite_overlay_if.slave    ld
);

  // Fixed two-cycle stream latency; informational only
  localparam int LATENCY = 2;

  logic [1:0]        state;
  logic [2:0]        ld_bmp_q;
  logic [3:0]        row_cnt;
  logic              wr_en;

  logic [STR_W-1:0]  stream_s1;
  logic [2:0]        color_s1;
  logic [3:0]        bitidx_s1;
  logic              hit_s1;
  logic              hit_d;
  logic [RAM_DW-1:0] rdata;
  logic              pix;
  logic [STR_W-1:0]  out_d;

  // Handshake outputs decode the state alone, never ld_valid_i
  assign ld.ld_ready_o = (state == LD_LOAD);
  assign ld.ld_done_o  = (state == LD_DONE);
  assign wr_en         = ld.ld_valid_i && (state == LD_LOAD);

  // Loader FSM: latch the target bitmap, accept 16 rows, pulse done once
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LD_IDLE;
      ld_bmp_q <= 3'd0;
      row_cnt  <= 4'd0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (ld.ld_start_i) begin
            ld_bmp_q <= ld.ld_bitmap_i;
            row_cnt  <= 4'd0;
            state    <= LD_LOAD;
          end
        end
        LD_LOAD: begin
          if (wr_en) begin
            row_cnt <= row_cnt + 4'd1;
            if (row_cnt == 4'd15) state <= LD_DONE;
          end
        end
        LD_DONE: state <= LD_IDLE;
        default: state <= LD_IDLE;
      endcase
    end
  end

  sprite_row_ram u_ram (
    .clk   (px_clk),
    .we    (wr_en),
    .waddr ({ld_bmp_q, row_cnt}),
    .wdata (ld.ld_data_i),
    .raddr (addr_i[AD_BMP_MSB:AD_ROW_LSB]),
    .rdata (rdata)
  );

  // Window hit for the incoming pixel, evaluated alongside the memory read
  always_comb begin
    hit_d = enable_i && RGBStr_i[ACTIVE_BIT]
         && in_span(RGBStr_i[XC_MSB:XC_LSB], posx_i, 10'(SPRITE_W))
         && in_span(RGBStr_i[YC_MSB:YC_LSB], posy_i, 10'(SPRITE_H));
  end

  // Stage 1: hold the pixel and its overlay context while the row is read
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      stream_s1 <= '0;
      color_s1  <= 3'd0;
      bitidx_s1 <= 4'd0;
      hit_s1    <= 1'b0;
    end else begin
      stream_s1 <= RGBStr_i;
      color_s1  <= color_i;
      bitidx_s1 <= addr_i[AD_BIT_MSB:AD_BIT_LSB];
      hit_s1    <= hit_d;
    end
  end

  // Replace only the RGB field when the pixel is in the window and set in the bitmap
  always_comb begin
    pix   = rdata[bitidx_s1];
    out_d = stream_s1;
    if (hit_s1 && pix) out_d[RGB_MSB:RGB_LSB] = color_s1;
  end

  // Stage 2: output register
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) RGBStr_o <= '0;
    else          RGBStr_o <= out_d;
  end

endmodule
